lm_log_manager: RTL and testbench

LM_LOG_MANAGER -- requirements
Module: lm_log_manager

---
 rtl/lm_log_manager_pkg.sv | 20 ++
 rtl/lm_echo_fifo.sv | 59 +++++
 rtl/lm_log_manager.sv | 191 +++++++++++++++++++
 tb/tb_lm_log_manager.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lm_log_manager_pkg.sv
// Shared widths, message header codes and FSM state type for the log manager.
package LM_item_pack;

  localparam int WIDTH_UART_DATA     = 8;
  localparam int WIDTH_VGA_ERROR     = 4;
  localparam int WIDTH_UART_ERROR    = 3;
  localparam int WIDTH_CONFIGURATION = 4;

  localparam logic [7:0] LM_HDR_UART_ERR = 8'hE2;
  localparam logic [7:0] LM_HDR_CM_ERR   = 8'hE1;
  localparam logic [7:0] LM_HDR_CFG      = 8'hC0;
  localparam logic [7:0] LM_HDR_ECHO     = 8'hD0;

  typedef enum logic [1:0] {
    LM_IDLE = 2'd0,
    LM_HDR  = 2'd1,
    LM_PAY  = 2'd2
  } lm_state_e;

endpackage

// File: rtl/lm_echo_fifo.sv
// Echo byte FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module lm_echo_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags and accepted push/pop qualifiers.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
    data      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Read and write pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/lm_log_manager.sv
// Log manager: serialises error, config and (with LM_ECHO_EN defined) UART echo events
// into two-byte header/payload messages over a valid/ready byte stream.
module lm_log_manager
  import LM_item_pack::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           UART_data_debug_switch,
  input  logic [WIDTH_UART_DATA-1:0]     UART_data,
  input  logic                           UART_data_valid,
  input  logic [WIDTH_VGA_ERROR-1:0]     CM_errors,
  input  logic                           CM_errors_valid,
  input  logic [WIDTH_UART_ERROR-1:0]    UART_errors,
  input  logic                           UART_errors_valid,
  input  logic [WIDTH_CONFIGURATION-1:0] config_notification,
  output logic [7:0]                     LM_tx_data,
  output logic                           LM_tx_valid,
  input  logic                           LM_tx_ready,
  output logic                           LM_busy,
  output logic [7:0]                     LM_drop_count
);

  lm_state_e state_r, state_s;

  logic                           uart_pend_r;
  logic [WIDTH_UART_ERROR-1:0]    uart_flags_r;
  logic                           cm_pend_r;
  logic [WIDTH_VGA_ERROR-1:0]     cm_flags_r;
  logic                           cfg_pend_r;
  logic [WIDTH_CONFIGURATION-1:0] cfg_prev_r;
  logic [WIDTH_CONFIGURATION-1:0] cfg_flags_r;
  logic [7:0]                     payload_r, payload_s;
  logic [7:0]                     tx_data_r, tx_data_s;
  logic                           tx_valid_r, tx_valid_s;
  logic                           busy_r;

  logic       sel_uart_s, sel_cm_s, sel_cfg_s, pop_s;
  logic       hs_s, cfg_ev_s;
  logic       echo_avail_s;
  logic [7:0] echo_data_s;

`ifdef LM_ECHO_EN
  logic       push_s, fifo_full_s, fifo_empty_s;
  logic [7:0] drop_r;

  lm_echo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WIDTH_UART_DATA)
  ) u_echo_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (UART_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .data  (echo_data_s)
  );

  assign push_s        = UART_data_valid & UART_data_debug_switch;
  assign echo_avail_s  = ~fifo_empty_s;
  assign LM_drop_count = drop_r;

  // Saturating count of echo bytes refused by a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= 8'h00;
    end else if (push_s && fifo_full_s && !pop_s && (drop_r != 8'hFF)) begin
      drop_r <= drop_r + 8'h01;
    end else begin
      drop_r <= drop_r;
    end
  end
`else
  logic unused_echo_s;

  assign echo_avail_s  = 1'b0;
  assign echo_data_s   = 8'h00;
  assign LM_drop_count = 8'h00;
  assign unused_echo_s = ^{UART_data, UART_data_valid, UART_data_debug_switch, pop_s, FIFO_DEPTH[0]};
`endif

  assign cfg_ev_s = (config_notification != cfg_prev_r);
  assign hs_s     = tx_valid_r & LM_tx_ready;

  // Source arbitration, next state and next registered output values.
  always_comb begin
    state_s    = state_r;
    sel_uart_s = 1'b0;
    sel_cm_s   = 1'b0;
    sel_cfg_s  = 1'b0;
    pop_s      = 1'b0;
    payload_s  = payload_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    case (state_r)
      LM_IDLE: begin
        tx_valid_s = 1'b1;
        state_s    = LM_HDR;
        if (uart_pend_r) begin
          sel_uart_s = 1'b1;
          tx_data_s  = LM_HDR_UART_ERR;
          payload_s  = 8'(uart_flags_r);
        end else if (cm_pend_r) begin
          sel_cm_s  = 1'b1;
          tx_data_s = LM_HDR_CM_ERR;
          payload_s = 8'(cm_flags_r);
        end else if (cfg_pend_r) begin
          sel_cfg_s = 1'b1;
          tx_data_s = LM_HDR_CFG;
          payload_s = 8'(cfg_flags_r);
        end else if (echo_avail_s) begin
          pop_s     = 1'b1;
          tx_data_s = LM_HDR_ECHO;
          payload_s = echo_data_s;
        end else begin
          tx_valid_s = 1'b0;
          tx_data_s  = 8'h00;
          state_s    = LM_IDLE;
        end
      end
      LM_HDR: begin
        if (hs_s) begin
          tx_data_s = payload_r;
          state_s   = LM_PAY;
        end else begin
          state_s = LM_HDR;
        end
      end
      LM_PAY: begin
        if (hs_s) begin
          tx_data_s  = 8'h00;
          tx_valid_s = 1'b0;
          state_s    = LM_IDLE;
        end else begin
          state_s = LM_PAY;
        end
      end
      default: begin
        tx_data_s  = 8'h00;
        tx_valid_s = 1'b0;
        state_s    = LM_IDLE;
      end
    endcase
  end

  // FSM state, snapshot payload and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= LM_IDLE;
      payload_r  <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      payload_r  <= payload_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      busy_r     <= (state_s != LM_IDLE);
    end
  end

  // Pending flags: a new event on the snapshot edge survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_pend_r  <= 1'b0;
      uart_flags_r <= '0;
      cm_pend_r    <= 1'b0;
      cm_flags_r   <= '0;
      cfg_pend_r   <= 1'b0;
      cfg_flags_r  <= '0;
      cfg_prev_r   <= '0;
    end else begin
      uart_pend_r  <= (uart_pend_r & ~sel_uart_s) | UART_errors_valid;
      uart_flags_r <= (sel_uart_s ? '0 : uart_flags_r) | (UART_errors_valid ? UART_errors : '0);
      cm_pend_r    <= (cm_pend_r & ~sel_cm_s) | CM_errors_valid;
      cm_flags_r   <= (sel_cm_s ? '0 : cm_flags_r) | (CM_errors_valid ? CM_errors : '0);
      cfg_pend_r   <= (cfg_pend_r & ~sel_cfg_s) | cfg_ev_s;
      cfg_flags_r  <= cfg_ev_s ? config_notification : cfg_flags_r;
      cfg_prev_r   <= config_notification;
    end
  end

  assign LM_tx_data  = tx_data_r;
  assign LM_tx_valid = tx_valid_r;
  assign LM_busy     = busy_r;

endmodule

// File: tb/tb_lm_log_manager.sv
// Directed self-checking bench for lm_log_manager; echo scenario depends on LM_ECHO_EN.
module tb_lm_log_manager;
  import LM_item_pack::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       UART_data_debug_switch;
  logic [7:0] UART_data;
  logic       UART_data_valid;
  logic [3:0] CM_errors;
  logic       CM_errors_valid;
  logic [2:0] UART_errors;
  logic       UART_errors_valid;
  logic [3:0] config_notification;
  logic [7:0] LM_tx_data;
  logic       LM_tx_valid;
  logic       LM_tx_ready;
  logic       LM_busy;
  logic [7:0] LM_drop_count;

  int errors = 0;
  int checks = 0;
  int seen;

  always #5 clk = ~clk;

  lm_log_manager #(.FIFO_DEPTH(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .UART_data_debug_switch (UART_data_debug_switch),
    .UART_data              (UART_data),
    .UART_data_valid        (UART_data_valid),
    .CM_errors              (CM_errors),
    .CM_errors_valid        (CM_errors_valid),
    .UART_errors            (UART_errors),
    .UART_errors_valid      (UART_errors_valid),
    .config_notification    (config_notification),
    .LM_tx_data             (LM_tx_data),
    .LM_tx_valid            (LM_tx_valid),
    .LM_tx_ready            (LM_tx_ready),
    .LM_busy                (LM_busy),
    .LM_drop_count          (LM_drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a valid byte, checks it, then lets one edge consume it.
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (LM_tx_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {7'h00, LM_tx_valid}, 8'h01);
    chk(tag, LM_tx_data, exp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    UART_data_debug_switch = 1'b0;
    UART_data = 8'h00;
    UART_data_valid = 1'b0;
    CM_errors = 4'h0;
    CM_errors_valid = 1'b0;
    UART_errors = 3'h0;
    UART_errors_valid = 1'b0;
    config_notification = 4'h0;
    LM_tx_ready = 1'b0;
    step();
    step();
    chk("rst_valid", {7'h00, LM_tx_valid}, 8'h00);
    chk("rst_data", LM_tx_data, 8'h00);
    chk("rst_busy", {7'h00, LM_busy}, 8'h00);
    chk("rst_drop", LM_drop_count, 8'h00);
    rst = 1'b0;
    step();
    chk("idle_busy", {7'h00, LM_busy}, 8'h00);

    // Simple CM error, with latency and return to idle.
    LM_tx_ready = 1'b1;
    CM_errors = 4'b0101;
    CM_errors_valid = 1'b1;
    step();
    CM_errors_valid = 1'b0;
    chk("s1_not_yet", {7'h00, LM_tx_valid}, 8'h00);
    step();
    chk("s1_hdr_valid", {7'h00, LM_tx_valid}, 8'h01);
    chk("s1_hdr", LM_tx_data, 8'hE1);
    chk("s1_busy", {7'h00, LM_busy}, 8'h01);
    step();
    chk("s1_pay", LM_tx_data, 8'h05);
    step();
    chk("s1_end_valid", {7'h00, LM_tx_valid}, 8'h00);
    chk("s1_end_busy", {7'h00, LM_busy}, 8'h00);

    // Priority: UART error beats CM error; one idle cycle between messages.
    UART_errors = 3'b011;
    UART_errors_valid = 1'b1;
    CM_errors = 4'b1000;
    CM_errors_valid = 1'b1;
    step();
    UART_errors_valid = 1'b0;
    CM_errors_valid = 1'b0;
    step();
    chk("s2_hdr1", LM_tx_data, 8'hE2);
    step();
    chk("s2_pay1", LM_tx_data, 8'h03);
    step();
    chk("s2_gap", {7'h00, LM_tx_valid}, 8'h00);
    step();
    chk("s2_hdr2", LM_tx_data, 8'hE1);
    step();
    chk("s2_pay2", LM_tx_data, 8'h08);
    step();
    chk("s2_end", {7'h00, LM_busy}, 8'h00);

    // Backpressure in HDR while UART errors accumulate.
    LM_tx_ready = 1'b0;
    CM_errors = 4'b0010;
    CM_errors_valid = 1'b1;
    step();
    CM_errors_valid = 1'b0;
    step();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        UART_errors = 3'b001;
        UART_errors_valid = 1'b1;
      end else if (i == 5) begin
        UART_errors = 3'b100;
        UART_errors_valid = 1'b1;
      end else begin
        UART_errors_valid = 1'b0;
      end
      step();
      if (LM_tx_data !== 8'hE1 || LM_tx_valid !== 1'b1) seen++;
    end
    UART_errors_valid = 1'b0;
    chk("s3_hold_unstable", seen[7:0], 8'h00);
    LM_tx_ready = 1'b1;
    step();
    chk("s3_pay1", LM_tx_data, 8'h02);
    step();
    expect_byte("s3_hdr2", 8'hE2);
    expect_byte("s3_pay2", 8'h05);
    chk("s3_end", {7'h00, LM_tx_valid}, 8'h00);

    // Config change to 3, then repeated unchanged value.
    config_notification = 4'h3;
    step();
    expect_byte("s4_hdr", 8'hC0);
    expect_byte("s4_pay", 8'h03);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      config_notification = 4'h3;
      step();
      if (LM_tx_valid === 1'b1) seen++;
    end
    chk("s4_single_msg", seen[7:0], 8'h00);

    // Echo overflow: one byte in flight plus four buffered, the rest dropped.
    UART_data_debug_switch = 1'b1;
    LM_tx_ready = 1'b0;
    for (int b = 8'h10; b <= 8'h16; b++) begin
      UART_data = 8'(b);
      UART_data_valid = 1'b1;
      step();
    end
    UART_data_valid = 1'b0;
`ifdef LM_ECHO_EN
    chk("s5_drop", LM_drop_count, 8'h02);
    LM_tx_ready = 1'b1;
    for (int b = 8'h10; b <= 8'h14; b++) begin
      expect_byte("s5_hdr", 8'hD0);
      expect_byte("s5_pay", 8'(b));
    end
    step();
    chk("s5_drained", {7'h00, LM_tx_valid}, 8'h00);
    chk("s5_drop_hold", LM_drop_count, 8'h02);
`else
    chk("s5_drop_tied", LM_drop_count, 8'h00);
    chk("s5_no_echo", {7'h00, LM_tx_valid}, 8'h00);
    LM_tx_ready = 1'b1;
    step();
    chk("s5_no_echo_busy", {7'h00, LM_busy}, 8'h00);
`endif
    UART_data_debug_switch = 1'b0;

    // Reset during PAY abandons the message.
    config_notification = 4'h0;
    step();
    step();
    step();
    step();
    LM_tx_ready = 1'b0;
    UART_errors = 3'b001;
    UART_errors_valid = 1'b1;
    step();
    UART_errors_valid = 1'b0;
    step();
    chk("s6_hdr", LM_tx_data, 8'hE2);
    LM_tx_ready = 1'b1;
    step();
    chk("s6_pay", LM_tx_data, 8'h01);
    LM_tx_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", {7'h00, LM_tx_valid}, 8'h00);
    chk("s6_rst_data", LM_tx_data, 8'h00);
    chk("s6_rst_busy", {7'h00, LM_busy}, 8'h00);
    chk("s6_rst_drop", LM_drop_count, 8'h00);
    step();
    rst = 1'b0;
    LM_tx_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (LM_tx_valid === 1'b1) seen++;
    end
    chk("s6_no_payload", seen[7:0], 8'h00);

    // Nonzero config at the first edge after reset release.
    rst = 1'b1;
    config_notification = 4'h6;
    step();
    rst = 1'b0;
    step();
    expect_byte("s7_hdr", 8'hC0);
    expect_byte("s7_pay", 8'h06);
    chk("s7_end", {7'h00, LM_busy}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
